// File: rtl/_alu_pkg.sv
// -----------------------------------------------------------------------------
// _alu_pkg
// Shared ALU datapath definitions:
//   - alu_state_e  : sequencing states of the multi-cycle arithmetic units
//   - ALU_WIDTH    : default operand width, shared by adder and subtractor
//   - nchunk()     : number of CHUNK-bit slices in a WIDTH-bit operand
// -----------------------------------------------------------------------------
package _alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/_addition_seq_impl_if.sv
// -----------------------------------------------------------------------------
// _addition_seq_impl_if
// Operand/result handshake bundle of the sequential adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (aer, and ovf when ADDER_OVF_EN)
// Modports:
//   master : producer/consumer side (operand fetch + writeback)
//   slave  : adder side
// Optional macro ADDER_OVF_EN adds the signed-overflow flag ovf.
// -----------------------------------------------------------------------------
interface _addition_seq_impl_if #(
    parameter int WIDTH = _alu_pkg::ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   aer;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, aer
`ifdef ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, aer
`ifdef ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/_chunk_adder_impl.sv
// -----------------------------------------------------------------------------
// _chunk_adder_impl
// Combinational CHUNK-bit carry-lookahead adder slice.
//   a, b : CHUNK-bit addends
//   cin  : carry into bit 0
//   sum  : CHUNK-bit sum
//   cout : carry out of the top bit
// Carries come from generate G = a&b and propagate P = a|b terms:
//   C[i+1] = G[i] | (P[i] & C[i]).
// -----------------------------------------------------------------------------
module _chunk_adder_impl #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK-1:0] g_s;
    logic [CHUNK-1:0] p_s;
    logic [CHUNK:0]   c_s;

    assign g_s    = a & b;
    assign p_s    = a | b;
    assign c_s[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_carry
        assign c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
    end

    // P is an OR term, so the sum bit must still use the XOR of the inputs.
    assign sum  = a ^ b ^ c_s[CHUNK-1:0];
    assign cout = c_s[CHUNK];

endmodule

// File: rtl/_addition_seq_impl.sv
// -----------------------------------------------------------------------------
// _addition_seq_impl
// Multi-cycle adder: aer = a + b + cin, computed CHUNK bits per clock through
// one shared carry-lookahead slice. aer[WIDTH] is the carry-out.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : _addition_seq_impl_if.slave (in_valid/in_ready/a/b/cin,
//          out_valid/out_ready/aer, plus ovf with ADDER_OVF_EN)
// Parameters: WIDTH (operand bits), CHUNK (bits per clock, divides WIDTH).
// Optional macro ADDER_OVF_EN: registered two's-complement overflow flag ovf.
// Timing: out_valid rises WIDTH/CHUNK cycles after the accept edge and holds
// with aer until out_ready; operands are only taken in IDLE.
// -----------------------------------------------------------------------------
module _addition_seq_impl
    import _alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    _addition_seq_impl_if.slave   bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUSY = ST_BUSY;
    localparam logic [1:0] DONE = ST_DONE;

    if ((CHUNK <= 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("_addition_seq_impl: WIDTH must be a positive multiple of CHUNK");
    end

    logic [1:0]       state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH:0]   aer_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             last_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] sum_s;
    logic             cout_s;

    assign in_ready_s = (state_r == IDLE) && !rst;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign last_s     = (idx_r == IDX_LAST);

    // Operand slices for the current chunk, taken from the latched copies.
    assign a_chunk_s = a_r[idx_r*CHUNK +: CHUNK];
    assign b_chunk_s = b_r[idx_r*CHUNK +: CHUNK];

    _chunk_adder_impl #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_chunk_s),
        .b    (b_chunk_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Control FSM, operand latches, chunk index, carry chain and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            aer_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.cin;
                        idx_r   <= '0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    aer_r[idx_r*CHUNK +: CHUNK] <= sum_s;
                    carry_r                     <= cout_s;
                    if (last_s) begin
                        aer_r[WIDTH] <= cout_s;
                        state_r      <= DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == DONE);
    assign bus.aer       = aer_r;

`ifdef ADDER_OVF_EN
    logic ovf_r;
    logic msb_cin_s;

    // Carry into the top bit, recovered from the top sum bit of the last chunk.
    assign msb_cin_s = sum_s[CHUNK-1] ^ a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1];

    // Signed overflow flag, captured on the final chunk and held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if ((state_r == BUSY) && last_s) begin
            ovf_r <= msb_cin_s ^ cout_s;
        end
    end

    assign bus.ovf = ovf_r;
`endif

endmodule

// File: doc/_addition_seq_impl.md
Name: _addition_seq_impl

Overview:
- Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through a carry-lookahead chunk stage.
- Forward-direction counterpart of the combinational subtractor in the ALU datapath.
- Valid/ready handshake on both sides, so it sits between the operand-fetch stage and the writeback stage with back-pressure.
- Result is WIDTH+1 bits; the MSB is carry-out.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits added per clock. WIDTH mod CHUNK must be 0; elaboration-time error otherwise.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- aer  out  WIDTH+1  sum; aer[WIDTH] is carry-out.

Behaviour:
- States: IDLE, BUSY, DONE. NCHUNK = WIDTH/CHUNK.
- Reset: state IDLE, out_valid 0, aer 0, chunk index 0, carry register 0. in_ready is 0 in any cycle where rst is high.
- in_ready = (state == IDLE) && !rst, combinational. out_valid = (state == DONE).
- IDLE: when in_valid && in_ready, latch a, b and cin; load the carry register with cin; set index 0; go to BUSY.
- BUSY: each cycle, add chunk[index] of a and b with the carry register and write it into aer[index*CHUNK +: CHUNK].
  - Update the carry register with the chunk carry-out.
  - If index == NCHUNK-1: write aer[WIDTH] with that carry-out and go to DONE. Otherwise increment index.
- DONE: aer and out_valid are held stable. On out_ready, go to IDLE. No operand accept in DONE, so there is no back-to-back overlap.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge (4 cycles at the defaults).
- Input changes on a, b, cin after the accept edge have no effect.
- Arithmetic is unsigned modulo 2^(WIDTH+1). No saturation.
- rst in any state returns to the reset values next edge. A partial result is discarded and never presented.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored; the producer holds its operands.

Optional Feature:
- Macro ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow, i.e. carry into the MSB XOR carry out of the MSB.
  - ovf is registered in the final BUSY cycle, valid in DONE, and 0 at reset.
- Undefined: the port is absent, no extra logic, behaviour otherwise identical.

Decomposition:
- Package _alu_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the default WIDTH constant (32), shared with the subtractor;
  - a function computing NCHUNK.
- Sub-module _chunk_adder_impl: combinational CHUNK-bit carry-lookahead adder.
  - Ports: a, b, cin, sum, cout.
  - Generate G = a&b, P = a|b, C[i+1] = G|(P&C).
  - Instantiated once and reused each BUSY cycle.

Test Plan:
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles out_valid=1, aer=0x1_00000000.
- a=0x12345678, b=0x11111111, cin=0 -> aer=0x0_23456789. a=0, b=0, cin=1 -> aer=0x0_00000001.
- Back-pressure: hold out_ready=0 for 10 cycles after DONE -> aer and out_valid stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 next cycle.
- Reset during BUSY at index 2 -> next cycle state IDLE, out_valid=0, aer=0, in_ready=1. A fresh op 5+7 -> aer=12.
- Operand change: after accept of 0x80000000+0x80000000, drive a=b=0 -> aer=0x1_00000000 (latched operands used).
- ADDER_OVF_EN defined:
  - 0x7FFFFFFF+0x00000001 -> ovf=1, aer=0x0_80000000.
  - 0xFFFFFFFF+0x00000001 -> ovf=0.
